// File: rtl/norm_lut_arbiter_pkg.sv
// ============================================================================
// Module      : norm_lut_arbiter_pkg
// Description : Shared FSM encoding and statistics width for norm_lut_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package norm_lut_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int STAT_WIDTH = 32;

endpackage

`default_nettype wire

// File: rtl/norm_lut_arbiter_rr_priority_picker.sv
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin pick: first set request at or above
//               the pointer (wrapping), returned as a one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/norm_lut_arbiter.sv
// ============================================================================
// Module      : norm_lut_arbiter
// Description : Round-robin, burst-locking arbiter in front of a shared LUT ROM
//               with a 2-cycle response path. Optional per-requester grant
//               counters enabled by `define NORM_LUT_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module norm_lut_arbiter
    import norm_lut_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rom_address,
    output logic                          rom_enable,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [NUM_REQ*STAT_WIDTH-1:0] stat_grant_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] C_ONE = NUM_REQ'(1);

    arb_state_e             r_state, w_state_nxt;
    logic [PTR_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [PTR_W-1:0]       r_owner, w_owner_nxt;
    logic [NUM_REQ-1:0]     w_pick_grant;
    logic [NUM_REQ-1:0]     w_owner_oh;
    logic [NUM_REQ-1:0]     w_grant;
    logic [PTR_W-1:0]       w_gidx;
    logic                   w_accept;
    logic                   w_sel_last;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [ADDR_WIDTH-1:0]  r_rom_addr_hold;
    logic                   r_p1_valid, r_p2_valid;
    logic [PTR_W-1:0]       r_p1_idx, r_p2_idx;
    logic [DATA_WIDTH-1:0]  r_resp_data;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_pick_grant)
    );

    assign w_owner_oh = C_ONE << r_owner;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        w_grant      = '0;
        w_gidx       = '0;
        case (r_state)
            ST_IDLE:   w_grant = w_pick_grant;
            ST_LOCKED: w_grant = req_valid & w_owner_oh;
            default:   w_grant = '0;
        endcase
        // Nothing is accepted while reset is asserted.
        if (!reset) begin
            w_grant = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = PTR_W'(i);
            end
        end
        w_accept   = |w_grant;
        w_sel_last = req_last[w_gidx];
        w_sel_addr = req_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH];
        if (w_accept) begin
            if (r_state == ST_IDLE && !w_sel_last) begin
                w_state_nxt = ST_LOCKED;
                w_owner_nxt = w_gidx;
            end else if (r_state == ST_LOCKED && w_sel_last) begin
                w_state_nxt = ST_IDLE;
            end
            if (w_sel_last) begin
                w_rr_ptr_nxt = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);
            end
        end
    end

    assign req_ready   = w_grant;
    assign rom_enable  = w_accept;
    assign rom_address = w_accept ? w_sel_addr : r_rom_addr_hold;

    // Index/valid ride alongside the ROM read: stage 1 = ROM cycle, stage 2 = output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rom_addr_hold <= '0;
            r_p1_valid      <= 1'b0;
            r_p1_idx        <= '0;
            r_p2_valid      <= 1'b0;
            r_p2_idx        <= '0;
            r_resp_data     <= '0;
        end else begin
            if (w_accept) begin
                r_rom_addr_hold <= w_sel_addr;
            end
            r_p1_valid <= w_accept;
            r_p1_idx   <= w_gidx;
            r_p2_valid <= r_p1_valid;
            r_p2_idx   <= r_p1_idx;
            if (r_p1_valid) begin
                r_resp_data <= rom_data;
            end
        end
    end

    assign resp_valid = r_p2_valid ? (C_ONE << r_p2_idx) : '0;
    assign resp_data  = r_resp_data;

`ifdef NORM_LUT_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_cnt
            logic [STAT_WIDTH-1:0] r_cnt;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else if (w_grant[gi] && (r_cnt != {STAT_WIDTH{1'b1}})) begin
                    r_cnt <= r_cnt + STAT_WIDTH'(1);
                end
            end
            assign stat_grant_cnt[gi*STAT_WIDTH +: STAT_WIDTH] = r_cnt;
        end
    endgenerate
`else
    assign stat_grant_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_norm_lut_arbiter.sv
// ============================================================================
// Module      : tb_norm_lut_arbiter
// Description : Directed, table-driven bench for norm_lut_arbiter with a
//               registered ROM model. Honours NORM_LUT_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_norm_lut_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int SW = 32;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   rom_address;
    logic            rom_enable;
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic [N*SW-1:0] stat_grant_cnt;

    int n_checks = 0;
    int n_err    = 0;

    norm_lut_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .rom_address    (rom_address),
        .rom_enable     (rom_enable),
        .rom_data       (rom_data),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .stat_grant_cnt (stat_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return 16'hC0DE ^ {a, 4'h5, a};
    endfunction

    always @(posedge clk) begin
        if (rom_enable) rom_data <= rom_fn(rom_address);
    end

    function automatic logic [N*AW-1:0] pk(input logic [AW-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*AW-1:0] addr;
        logic [N-1:0]    last;
        logic [N-1:0]    exp_ready;
        logic [AW-1:0]   exp_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N-1:0] l,
                       input logic [N-1:0] er, input logic [AW-1:0] ea);
        vec_t t;
        t.valid = v; t.addr = a; t.last = l; t.exp_ready = er; t.exp_addr = ea;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N-1:0] l);
        @(posedge clk);
        #1;
        req_valid = v; req_addr = a; req_last = l;
    endtask

    task automatic check_stats(input string tag, input logic [SW-1:0] e3);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_stat%0d", tag, i), 64'(stat_grant_cnt[i*SW +: SW]),
                (i == 3) ? 64'(e3) : 64'd0);
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = '1; req_addr = '0; req_last = '1;

        // Round-robin from reset: 0,1,2,3,0
        add(4'b1111, pk(6'h10, 6'h11, 6'h12, 6'h13), 4'b1111, 4'b0001, 6'h10);
        add(4'b1111, pk(6'h10, 6'h11, 6'h12, 6'h13), 4'b1111, 4'b0010, 6'h11);
        add(4'b1111, pk(6'h10, 6'h11, 6'h12, 6'h13), 4'b1111, 4'b0100, 6'h12);
        add(4'b1111, pk(6'h10, 6'h11, 6'h12, 6'h13), 4'b1111, 4'b1000, 6'h13);
        add(4'b1111, pk(6'h10, 6'h11, 6'h12, 6'h13), 4'b1111, 4'b0001, 6'h10);
        // Single beat from requester 2 at address 5, then idle (address held)
        add(4'b0100, pk(6'h00, 6'h00, 6'h05, 6'h00), 4'b0100, 4'b0100, 6'h05);
        add(4'b0000, pk(6'h00, 6'h00, 6'h00, 6'h00), 4'b0000, 4'b0000, 6'h05);
        add(4'b0000, pk(6'h00, 6'h00, 6'h00, 6'h00), 4'b0000, 4'b0000, 6'h05);
        // Move pointer to 1, then burst lock: 1,1,1, skip 2, 3, 0
        add(4'b0001, pk(6'h20, 6'h00, 6'h00, 6'h00), 4'b0001, 4'b0001, 6'h20);
        add(4'b1011, pk(6'h30, 6'h31, 6'h00, 6'h33), 4'b1001, 4'b0010, 6'h31);
        add(4'b1011, pk(6'h30, 6'h32, 6'h00, 6'h33), 4'b1001, 4'b0010, 6'h32);
        add(4'b1011, pk(6'h30, 6'h34, 6'h00, 6'h33), 4'b1011, 4'b0010, 6'h34);
        add(4'b1001, pk(6'h30, 6'h00, 6'h00, 6'h33), 4'b1001, 4'b1000, 6'h33);
        add(4'b0001, pk(6'h30, 6'h00, 6'h00, 6'h00), 4'b0001, 4'b0001, 6'h30);
        // Owner gap: requester 2 locks, drops valid 2 cycles, others stalled
        add(4'b0100, pk(6'h00, 6'h00, 6'h3A, 6'h00), 4'b0000, 4'b0100, 6'h3A);
        add(4'b1011, pk(6'h01, 6'h02, 6'h00, 6'h03), 4'b1111, 4'b0000, 6'h3A);
        add(4'b1011, pk(6'h01, 6'h02, 6'h00, 6'h03), 4'b1111, 4'b0000, 6'h3A);
        add(4'b1111, pk(6'h01, 6'h02, 6'h3B, 6'h03), 4'b0100, 4'b0100, 6'h3B);
        add(4'b1111, pk(6'h01, 6'h02, 6'h3C, 6'h03), 4'b1111, 4'b1000, 6'h03);
        add(4'b0000, pk(6'h00, 6'h00, 6'h00, 6'h00), 4'b0000, 4'b0000, 6'h03);
        add(4'b0000, pk(6'h00, 6'h00, 6'h00, 6'h00), 4'b0000, 4'b0000, 6'h03);

        // Reset state, with requests present
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rom_en", 64'(rom_enable), 64'd0);
        chk("rst_rom_addr", 64'(rom_address), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        check_stats("rst", 32'd0);
        req_valid = '0; req_last = '0;
        reset = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].valid, tbl[k].addr, tbl[k].last);
            @(negedge clk);
            chk($sformatf("v%0d_ready", k), 64'(req_ready), 64'(tbl[k].exp_ready));
            chk($sformatf("v%0d_rom_en", k), 64'(rom_enable), 64'(|tbl[k].exp_ready));
            chk($sformatf("v%0d_rom_addr", k), 64'(rom_address), 64'(tbl[k].exp_addr));
            if (k >= 2) begin
                chk($sformatf("v%0d_resp_valid", k), 64'(resp_valid), 64'(tbl[k-2].exp_ready));
                if (tbl[k-2].exp_ready != '0)
                    chk($sformatf("v%0d_resp_data", k), 64'(resp_data), 64'(rom_fn(tbl[k-2].exp_addr)));
            end else begin
                chk($sformatf("v%0d_resp_valid", k), 64'(resp_valid), 64'd0);
            end
        end

        // Reset mid-burst with two reads in flight
        drive(4'b0010, pk(6'h00, 6'h07, 6'h00, 6'h00), 4'b0000);
        @(negedge clk);
        chk("mb_beat1", 64'(req_ready), 64'b0010);
        drive(4'b0010, pk(6'h00, 6'h08, 6'h00, 6'h00), 4'b0000);
        @(negedge clk);
        chk("mb_beat2", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1;
        reset = 1'b0; req_valid = 4'b1111; req_last = 4'b1111;
        #1;
        chk("mb_rst_resp", 64'(resp_valid), 64'd0);
        chk("mb_rst_ready", 64'(req_ready), 64'd0);
        chk("mb_rst_rom_en", 64'(rom_enable), 64'd0);
        chk("mb_rst_rom_addr", 64'(rom_address), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1; req_valid = '0; req_last = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mb_quiet%0d", c), 64'(resp_valid), 64'd0);
            @(posedge clk);
        end
        #1;
        req_valid = 4'b1111; req_last = 4'b1111; req_addr = pk(6'h01, 6'h02, 6'h03, 6'h04);
        @(negedge clk);
        chk("mb_first_grant", 64'(req_ready), 64'b0001);
        drive(4'b0000, '0, 4'b0000);
        @(negedge clk);
        chk("mb_after_grant", 64'(req_ready), 64'd0);

        // Ten beats from requester 3 after a fresh reset
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_stats("st0", 32'd0);
        for (int b = 0; b < 10; b++) begin
            drive(4'b1000, pk(6'h00, 6'h00, 6'h00, 6'(b)), 4'b1000);
            @(negedge clk);
            chk($sformatf("st_beat%0d", b), 64'(req_ready), 64'b1000);
        end
        drive(4'b0000, '0, 4'b0000);
        @(negedge clk);
`ifdef NORM_LUT_ARB_STATS_EN
        check_stats("st10", 32'd10);
`else
        check_stats("st10", 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/norm_lut_arbiter.md
NORM_LUT_ARBITER -- requirements
Module: norm_lut_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, LUT address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, LUT word width.
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester lookup request.
REQ-007 SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port req_last  input  NUM_REQ  final beat of a burst.
REQ-009 SHALL have port req_ready  output  NUM_REQ  beat accepted this cycle (one-hot or zero).
REQ-010 SHALL have port rom_address  output  ADDR_WIDTH  and port rom_enable  output  1, driving the shared LUT ROM.
REQ-011 SHALL have port rom_data  input  DATA_WIDTH  LUT ROM registered output, valid one cycle after rom_enable.
REQ-012 SHALL have port resp_valid  output  NUM_REQ  and port resp_data  output  DATA_WIDTH  (shared bus, qualified by resp_valid).
REQ-013 SHALL have port stat_grant_cnt  output  NUM_REQ*32  per-requester accepted-beat counters.

Function
REQ-014 SHALL accept a beat from requester i in cycle t iff req_valid[i] and i is the granted requester; req_ready[i]=1 combinationally that cycle.
REQ-015 SHALL drive rom_enable=1 and rom_address=req_addr[i] in the accept cycle, else rom_enable=0 and rom_address holds its last value.
REQ-016 SHALL assert resp_valid[i] for exactly one cycle at t+2, with resp_data = ROM word for that address (one ROM cycle plus one output register).
REQ-017 SHALL sustain one accepted beat per cycle; responses return in acceptance order; requesters have no response back-pressure.
REQ-018 SHALL implement FSM states IDLE and LOCKED.
REQ-019 In IDLE, SHALL grant the first valid requester searching upward (mod NUM_REQ) from rr_ptr.
REQ-020 IDLE->LOCKED when the accepted beat has req_last=0; owner := granted requester.
REQ-021 In LOCKED, only the owner is eligible; owner valid low -> no issue, stay LOCKED, others stalled.
REQ-022 LOCKED->IDLE when owner beat accepted with req_last=1; IDLE beat with req_last=1 stays IDLE.
REQ-023 rr_ptr SHALL update to (granted+1) mod NUM_REQ on every accepted beat with req_last=1, unchanged otherwise.
REQ-024 Requester index and valid SHALL travel a 2-stage pipeline alongside the ROM read; nothing else buffered.

Reset
REQ-025 On reset low: state=IDLE, rr_ptr=0, owner=0, pipeline valids=0, req_ready=0, rom_enable=0, rom_address=0, resp_valid=0, resp_data=0, stat_grant_cnt=0.
REQ-026 Reset mid-burst or with reads in flight SHALL discard them; no resp_valid after reset release until new accepts.

Configuration
REQ-027 With NORM_LUT_ARB_STATS_EN defined, stat_grant_cnt[i] SHALL increment per accepted beat of requester i, saturating at 32'hFFFF_FFFF.
REQ-028 Without NORM_LUT_ARB_STATS_EN, stat_grant_cnt SHALL be constant 0 and no counter flops synthesized.

Structure
REQ-029 Shared package SHALL hold FSM state encoding (IDLE=1'b0, LOCKED=1'b1) and stat counter width (32).
REQ-030 Round-robin pick SHALL be sub-module rr_priority_picker (request vector, pointer -> one-hot grant, combinational).
REQ-031 LUT ROM SHALL stay outside this block; parent connects rom_* ports.

Verification
REQ-032 Single beat: req_valid[2]=1, addr=6'h05, last=1 at t -> req_ready[2]=1 at t, rom_address=5 at t, resp_valid[2]=1 at t+2 with mem[5].
REQ-033 Round-robin: all four valid, last=1 every cycle from reset -> grant order 0,1,2,3,0; four responses back-to-back.
REQ-034 Burst lock: req 1 burst of 3 (last on 3rd), req 0 and 3 valid -> 1,1,1 granted, then 2 skipped (idle), 3 next, then 0.
REQ-035 Owner gap: owner valid low 2 cycles mid-burst, others valid -> no grants, rom_enable=0 those cycles, then burst resumes.
REQ-036 Reset mid-burst with 2 reads in flight -> no resp_valid after release; state IDLE; next grant from requester 0.
REQ-037 With NORM_LUT_ARB_STATS_EN: 10 beats from req 3 -> stat_grant_cnt[3]=10, others 0; without macro all 0.
